// File: rtl/isp_stream_unpack.sv
// Unpacks the 4-pixel/clock ISP AXI-Stream into a 1-pixel/clock stream and
// flags input lines whose word count differs from LINE_WORDS.
module isp_stream_unpack #(
  parameter int unsigned LINE_WORDS = 480
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [95:0] I_tdata,
  input  logic        I_tvalid,
  output logic        I_tready,
  input  logic        I_tuser,
  input  logic        I_tlast,
  output logic [23:0] O_tdata,
  output logic        O_tvalid,
  input  logic        O_tready,
  output logic        O_tuser,
  output logic        O_tlast,
  output logic        O_len_err
);

  localparam int unsigned WW = $clog2(LINE_WORDS + 1);

  logic [95:0]   buf_data;
  logic          buf_tuser;
  logic          buf_tlast;
  logic          buf_v;
  logic [1:0]    cnt;
  logic [WW-1:0] wcnt;
  logic          len_err;
  logic          load;
  logic [WW-1:0] idx;

  // A new word may enter when empty, or while lane 3 is leaving (no bubble).
  assign I_tready = !I_rst && (!buf_v || (O_tready && cnt == 2'd3));
  assign load     = I_tvalid && I_tready;

  // Position of the incoming word within its line, 1-based.
  assign idx = I_tuser ? WW'(1) : wcnt + WW'(1);

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      buf_data  <= '0;
      buf_tuser <= 1'b0;
      buf_tlast <= 1'b0;
      buf_v     <= 1'b0;
      cnt       <= 2'd0;
      wcnt      <= '0;
      len_err   <= 1'b0;
    end else begin
      len_err <= 1'b0;
      if (load) begin
        buf_data  <= I_tdata;
        buf_tuser <= I_tuser;
        buf_tlast <= I_tlast;
        buf_v     <= 1'b1;
        cnt       <= 2'd0;
        if (I_tlast) begin
          len_err <= (idx != WW'(LINE_WORDS));
          wcnt    <= '0;
        end else if (idx == WW'(LINE_WORDS)) begin
          len_err <= 1'b1;
          wcnt    <= '0;
        end else begin
          wcnt <= idx;
        end
      end else if (buf_v && O_tready) begin
        if (cnt == 2'd3) begin
          cnt   <= 2'd0;
          buf_v <= 1'b0;
        end else begin
          cnt <= cnt + 2'd1;
        end
      end
    end
  end

  // Lane select; lane 0 occupies the low bits and goes out first.
  always_comb begin
    O_tdata = buf_data[23:0];
    case (cnt)
      2'd0:    O_tdata = buf_data[23:0];
      2'd1:    O_tdata = buf_data[47:24];
      2'd2:    O_tdata = buf_data[71:48];
      default: O_tdata = buf_data[95:72];
    endcase
  end

  assign O_tvalid  = buf_v;
  assign O_tuser   = buf_tuser && (cnt == 2'd0);
  assign O_tlast   = buf_tlast && (cnt == 2'd3);
  assign O_len_err = len_err;

endmodule

// File: tb/tb_isp_stream_unpack.sv
// Directed bench for isp_stream_unpack: flow, backpressure, frame markers,
// line-length errors and mid-word reset.
module tb_isp_stream_unpack;

  logic        clk;
  logic        rst;
  logic [95:0] i_tdata;
  logic        i_tvalid;
  logic        i_tready;
  logic        i_tuser;
  logic        i_tlast;
  logic [23:0] o_tdata;
  logic        o_tvalid;
  logic        o_tready;
  logic        o_tuser;
  logic        o_tlast;
  logic        o_len_err;

  isp_stream_unpack #(.LINE_WORDS(480)) dut (
    .I_clk     (clk),
    .I_rst     (rst),
    .I_tdata   (i_tdata),
    .I_tvalid  (i_tvalid),
    .I_tready  (i_tready),
    .I_tuser   (i_tuser),
    .I_tlast   (i_tlast),
    .O_tdata   (o_tdata),
    .O_tvalid  (o_tvalid),
    .O_tready  (o_tready),
    .O_tuser   (o_tuser),
    .O_tlast   (o_tlast),
    .O_len_err (o_len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] d;
    logic        u;
    logic        l;
  } word_t;

  word_t       in_q[$];
  logic [31:0] exp_q[$];

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          tk;
  int          acc_total;
  int          prev_acc;
  int          err_pulses;
  int          err_at;
  bit          prev_err;
  bit          stall_prev;
  logic [26:0] stall_val;
  bit          popped;
  bit          gap_mode;
  bit          rand_rdy;
  bit          mon_en;
  logic [15:0] ov_v;
  logic [15:0] ir_v;
  logic [23:0] pix_ctr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push_word(input logic [95:0] d, input logic u, input logic l);
    word_t w;
    w.d = d; w.u = u; w.l = l;
    in_q.push_back(w);
    for (int k = 0; k < 4; k++)
      exp_q.push_back({6'd0, u && (k == 0), l && (k == 3), d[24*k +: 24]});
  endtask

  // n words with sequential pixel values; tuser on word 1 if asked, tlast on word last_at.
  task automatic add_words(input int n, input bit first_user, input int last_at);
    logic [95:0] d;
    for (int i = 1; i <= n; i++) begin
      for (int k = 0; k < 4; k++) begin
        d[24*k +: 24] = pix_ctr;
        pix_ctr = pix_ctr + 24'd1;
      end
      push_word(d, first_user && (i == 1), i == last_at);
    end
  endtask

  // One clock: drive at the falling edge, observe handshakes just after, let the rising edge pass.
  task automatic tick();
    logic [31:0] expv;
    if (popped || !i_tvalid) begin
      popped = 1'b0;
      if (in_q.size() > 0 && (!gap_mode || $urandom_range(0, 3) != 0)) begin
        i_tvalid = 1'b1;
        i_tdata  = in_q[0].d;
        i_tuser  = in_q[0].u;
        i_tlast  = in_q[0].l;
      end else begin
        i_tvalid = 1'b0;
      end
    end
    o_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    if (prev_err) check("len_err_one_cycle", {31'd0, o_len_err}, 32'd0);
    if (o_len_err) begin
      err_pulses++;
      err_at = prev_acc;
    end
    prev_err = o_len_err;
    if (stall_prev) check("stall_hold", {5'd0, o_tvalid, o_tuser, o_tlast, o_tdata}, {5'd0, stall_val});
    stall_prev = o_tvalid && !o_tready;
    stall_val  = {o_tvalid, o_tuser, o_tlast, o_tdata};
    if (tk < 16) begin
      ov_v[tk[3:0]] = o_tvalid;
      ir_v[tk[3:0]] = i_tready;
    end
    if (mon_en && o_tvalid && o_tready) begin
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
      check("pixel", {6'd0, o_tuser, o_tlast, o_tdata}, expv);
    end
    if (i_tvalid && i_tready) begin
      acc_total++;
      prev_acc = acc_total;
      void'(in_q.pop_front());
      popped = 1'b1;
    end else begin
      prev_acc = 0;
    end
    tk++;
    @(negedge clk);
  endtask

  task automatic run(input int max_cycles);
    int n = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n < max_cycles) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("drain", in_q.size() + exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    i_tvalid = 1'b0;
    i_tdata  = '0;
    i_tuser  = 1'b0;
    i_tlast  = 1'b0;
    o_tready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", {26'd0, o_tvalid, o_tuser, o_tlast, o_len_err, i_tready, |o_tdata}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_release_ready", {31'd0, i_tready}, 32'd1);
    @(negedge clk);
    in_q.delete();
    exp_q.delete();
    tk = 0; acc_total = 0; prev_acc = 0; err_pulses = 0; err_at = 0;
    prev_err = 0; stall_prev = 0; popped = 0; gap_mode = 0; rand_rdy = 0; mon_en = 1;
    ov_v = '0; ir_v = '0;
  endtask

  initial begin
    rst = 1'b1; i_tvalid = 1'b0; i_tdata = '0; i_tuser = 1'b0; i_tlast = 1'b0; o_tready = 1'b0;

    // Continuous flow: pixels 1..12, I_tready once per 4 cycles, no gaps.
    do_reset();
    pix_ctr = 24'd1;
    add_words(3, 0, 0);
    run(100);
    check("cont_valid_pattern", {16'd0, ov_v}, 32'h1FFE);
    check("cont_ready_pattern", {16'd0, ir_v}, 32'hF111);
    check("cont_no_err", err_pulses, 32'd0);

    // Full frame line: tuser only on pixel 0, tlast only on pixel 1919.
    do_reset();
    pix_ctr = 24'h100000;
    add_words(480, 1, 480);
    run(3000);
    check("frame_no_err", err_pulses, 32'd0);

    // Short line then a correct line counted from 1.
    do_reset();
    pix_ctr = 24'h200000;
    add_words(479, 1, 479);
    add_words(480, 0, 480);
    run(6000);
    check("short_err_count", err_pulses, 32'd1);
    check("short_err_word", err_at, 32'd479);

    // Long line: error after word 480, following line clean.
    do_reset();
    pix_ctr = 24'h300000;
    add_words(480, 1, 0);
    add_words(480, 0, 480);
    run(6000);
    check("long_err_count", err_pulses, 32'd1);
    check("long_err_word", err_at, 32'd480);

    // tuser and tlast on the same word: a 1-word line.
    do_reset();
    pix_ctr = 24'h400000;
    add_words(1, 1, 1);
    run(100);
    check("single_err_count", err_pulses, 32'd1);
    check("single_err_word", err_at, 32'd1);

    // Random backpressure and input gaps over 1000 words.
    do_reset();
    pix_ctr = 24'h500000;
    gap_mode = 1; rand_rdy = 1;
    add_words(480, 1, 480);
    add_words(480, 0, 480);
    add_words(40, 0, 0);
    run(20000);
    check("random_no_err", err_pulses, 32'd0);
    check("random_words", acc_total, 32'd1000);

    // Reset while lane 2 is on the output.
    do_reset();
    push_word({24'hA3A3A3, 24'hA2A2A2, 24'hA1A1A1, 24'hA0A0A0}, 1'b1, 1'b0);
    push_word({24'hB3B3B3, 24'hB2B2B2, 24'hB1B1B1, 24'hB0B0B0}, 1'b0, 1'b0);
    repeat (3) tick();
    #1;
    check("pre_reset_lane2", {8'd0, o_tdata}, 32'h00A2A2A2);
    rst = 1'b1;
    mon_en = 0;
    #1;
    check("reset_ready_low", {31'd0, i_tready}, 32'd0);
    tick();
    #1;
    check("midreset_outputs", {26'd0, o_tvalid, o_tuser, o_tlast, o_len_err, i_tready, |o_tdata}, 32'd0);
    rst = 1'b0;
    i_tvalid = 1'b0;
    popped = 0;
    in_q.delete();
    exp_q.delete();
    mon_en = 1;
    @(negedge clk);
    push_word({24'hC3C3C3, 24'hC2C2C2, 24'hC1C1C1, 24'hC0C0C0}, 1'b1, 1'b0);
    run(100);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/isp_stream_unpack.md
# isp_stream_unpack

Width converter from the 4-pixel-per-clock ISP video stream to a 1-pixel-per-clock stream. It accepts the 96-bit, four-lane RGB888 AXI-Stream produced by the ISP stages, such as the saturation, colour and gamma blocks. It emits one 24-bit RGB888 pixel per transfer toward single-pixel consumers such as the scaler, the face-detect front end or the HDMI timing gen. It honours backpressure on both sides, and it checks line length against the configured width.

## Interface
- LINE_WORDS, 480: number of 96-bit input words per line (H_ACTIVE/4; 480 = 1920 px).
- I_clk  in  1  clock; all logic on the rising edge.
- I_rst  in  1  synchronous reset, active-high.
- I_tdata  in  96  four pixels; lane k = [24k+23:24k], each lane {R[23:16],G[15:8],B[7:0]}.
- I_tvalid  in  1  input word valid.
- I_tready  out  1  input word accepted when I_tvalid && I_tready.
- I_tuser  in  1  start of frame; qualifies the whole word.
- I_tlast  in  1  end of line; qualifies the whole word.
- O_tdata  out  24  one RGB888 pixel.
- O_tvalid  out  1  output pixel valid.
- O_tready  in  1  downstream ready.
- O_tuser  out  1  start of frame, on lane-0 pixel only.
- O_tlast  out  1  end of line, on lane-3 pixel only.
- O_len_err  out  1  one-cycle pulse on a line-length violation.

## Operation
- State:
  - word buffer: 96-bit data, tuser and tlast flags, buf_v;
  - lane counter cnt[1:0];
  - input word counter wcnt of ceil(log2(LINE_WORDS+1)) bits.
- Outputs:
  - O_tvalid = buf_v.
  - O_tdata = buf_data[24*cnt +: 24].
  - O_tuser = buf_tuser && cnt==0.
  - O_tlast = buf_tlast && cnt==3.
- Lanes are emitted in order 0,1,2,3; lane 0 (bits [23:0]) goes first.
- Output transfer (O_tvalid && O_tready):
  - cnt != 3: cnt increments.
  - cnt == 3: cnt returns to 0, and buf_v <= I_tvalid.
  - In the cnt == 3 case the buffer reloads from the input in the same cycle, so there is no bubble.
- Output stalled (O_tready = 0): buffer, cnt and all O_* hold stable.
- I_tready = !I_rst && (!buf_v || (O_tready && cnt==3)).
  - This is combinational from O_tready, and it is the only combinational in-to-out path.
- Buffer empty: an accepted word loads buf_data, tuser and tlast, and sets buf_v with cnt=0.
- Line check, evaluated on each accepted input word:
  - tuser=1: wcnt restarts, and the word counts as word 1.
  - tlast=1:
    - if the word's index (wcnt+1, or 1 when tuser is also set) != LINE_WORDS, pulse O_len_err the next cycle;
    - wcnt <= 0.
  - tlast=0 and the word's index == LINE_WORDS: pulse O_len_err (missing tlast), then wcnt <= 0.
  - Otherwise wcnt increments.
- Data is never altered. tuser and tlast pass through unmodified even when O_len_err fires.
- Reset, including mid-line:
  - buf_v=0, cnt=0, wcnt=0, buffer data and flags 0.
  - O_tvalid=0, O_tdata=0, O_tuser=0, O_tlast=0, O_len_err=0, I_tready=0.
  - Any partially emitted word is discarded.

## Timing
- Latency: a word accepted on edge N presents lane 0 on O_* after edge N, i.e. valid in cycle N+1.
- Throughput:
  - with O_tready held high, 1 pixel/clock on the output;
  - the input is accepted 1 cycle in 4;
  - I_tready is high in the cycle lane 3 is being taken.
- A word accepted with O_tready high continuously gives lanes 0..3 in cycles N+1..N+4, and the next word's lane 0 in cycle N+5.
- Input stall (I_tvalid=0 when lane 3 transfers): buf_v goes 0 the next cycle, and O_tvalid drops.
- O_len_err asserts for exactly one cycle, on the cycle after the offending input handshake.

## Test plan
- Continuous flow: 3 words with pixel values 0x000001..0x00000C, O_tready=1 → O_tdata is 0x000001..0x00000C on 12 consecutive cycles; I_tready high once every 4 cycles; no gaps.
- Random backpressure: O_tready toggles randomly at 50% for 1000 words → output pixel sequence equals the input lanes in order, and O_tdata, O_tuser and O_tlast are stable whenever O_tvalid && !O_tready.
- Frame markers: first word with tuser=1, word 480 with tlast=1 → O_tuser only on pixel 0; O_tlast only on pixel 1919; O_len_err never asserts.
- Short line: tlast on word 479 → O_len_err pulses 1 cycle; the next line still counts from 1.
- Long line: no tlast by word 480 → O_len_err pulses after word 480's handshake; word 481 counts as index 1.
- Mid-word reset: assert I_rst while cnt==2 → the next cycle shows O_tvalid=0, I_tready=0 and all outputs 0; after release, the first new word is output starting at lane 0.
